melody_pattern_writer: RTL

//  Feeds the memory-game core: generates a pseudo-random 8-note melody, packs it
//  as 3-bit note codes in 4-bit lanes, then issues the write and start pulses.

---
 rtl/melody_pattern_writer_if.sv | 25 ++
 rtl/melody_pattern_writer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/melody_pattern_writer_if.sv
// Bus between the melody writer and the memory-game core:
// packed melody, write/start/reset pulses and the core's end flag.
interface melody_pattern_writer_if;
    logic [31:0] data_out;
    logic        write_enable;
    logic        game_start;
    logic        game_rst;
    logic        game_end;

    modport master (
        output data_out,
        output write_enable,
        output game_start,
        output game_rst,
        input  game_end
    );

    modport slave (
        input  data_out,
        input  write_enable,
        input  game_start,
        input  game_rst,
        output game_end
    );
endinterface

// File: rtl/melody_pattern_writer.sv
// Generates LFSR melodies for the memory-game core and sequences its rounds.
// Optional: define MELODY_NO_REPEAT_EN to forbid adjacent repeated notes.
module melody_pattern_writer #(
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int          COOLDOWN_CYCLES = 16,
    parameter int          NOTES           = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_req,
    input  logic                            auto_next,
    input  logic                            seed_load,
    input  logic [15:0]                     seed_in,
    melody_pattern_writer_if.master         core,
    output logic                            busy,
    output logic [7:0]                      round_count,
    output logic [2:0]                      state_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_COOL  = 3'd5;

    localparam logic [15:0] DEF_SEED  = 16'hACE1;
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0) ? DEF_SEED : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          CW        = (COOLDOWN_CYCLES > 1) ?
                                        $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(NOTES - 1);

    logic [2:0]    r_state;
    logic [15:0]   r_lfsr;
    logic [31:0]   r_data;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_cool;
    logic          r_game_end_d;
    logic [7:0]    r_round;

    logic [2:0]    w_cand;
    logic [15:0]   w_lfsr_next;
    logic [15:0]   w_seed;
    logic          w_accept;
    logic          w_last;
    logic          w_end_rise;

    assign w_cand      = r_lfsr[2:0];
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0);
    assign w_seed      = (seed_in == 16'h0) ? DEF_SEED : seed_in;
    assign w_end_rise  = core.game_end & ~r_game_end_d;

`ifdef MELODY_NO_REPEAT_EN
    logic [2:0] r_prev;

    assign w_accept = (w_cand != 3'd0) &&
                      ((r_idx == 3'd0) || (w_cand != r_prev));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_prev <= 3'd0;
        else if (r_state == S_GEN && w_accept)
            r_prev <= w_cand;
    end
`else
    assign w_accept = (w_cand != 3'd0);
`endif

    assign w_last = w_accept && (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lfsr       <= SEED_EFF;
            r_data       <= 32'h0;
            r_idx        <= 3'd0;
            r_cool       <= '0;
            r_game_end_d <= 1'b0;
            r_round      <= 8'd0;
        end else begin
            r_game_end_d <= core.game_end;
            unique case (r_state)
                S_IDLE: begin
                    // a seed loaded alongside start_req feeds the first candidate
                    if (seed_load)
                        r_lfsr <= w_seed;
                    if (start_req) begin
                        r_state <= S_GEN;
                        r_data  <= 32'h0;
                        r_idx   <= 3'd0;
                    end
                end
                S_GEN: begin
                    r_lfsr <= w_lfsr_next;
                    if (w_accept) begin
                        r_data[{r_idx, 2'b00} +: 4] <= {1'b0, w_cand};
                        r_idx <= r_idx + 3'd1;
                        if (w_last)
                            r_state <= S_WRITE;
                    end
                end
                S_WRITE: r_state <= S_START;
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_end_rise) begin
                        r_state <= S_COOL;
                        r_cool  <= COOL_LOAD;
                        if (r_round != 8'hFF)
                            r_round <= r_round + 8'd1;
                    end
                end
                S_COOL: begin
                    if (r_cool == '0) begin
                        if (auto_next) begin
                            r_state <= S_GEN;
                            r_data  <= 32'h0;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cool <= r_cool - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core.data_out     = r_data;
    assign core.write_enable = (r_state == S_WRITE);
    assign core.game_start   = (r_state == S_START);
    assign core.game_rst     = (r_state == S_COOL) && (r_cool == COOL_LOAD);
    assign busy              = (r_state != S_IDLE);
    assign round_count       = r_round;
    assign state_out         = r_state;

endmodule
